// File: rtl/async_cpu_pkg.sv
// Shared types and widths for the asynchronous-handshake CPU pipeline.
// Four-phase stages reuse hs_state_t for their req/ack controllers.
package async_cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single-bit level crossing into clk.
// Clears asynchronously so a reset never leaves a stale ack behind.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/if_id_channel.sv
// Fetch-to-decode channel: valid/ready in, small FIFO, four-phase req/ack out.
// A flush keeps only the word decode is already looking at.
module if_id_channel #(
  parameter int INSTR_W     = async_cpu_pkg::INSTR_W,
  parameter int PC_W        = async_cpu_pkg::PC_W,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [INSTR_W-1:0]         fetch_instr,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       flush,
  output logic                       req,
  input  logic                       ack,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [PC_W-1:0]            pc_out,
  output logic [$clog2(DEPTH):0]     count
);

  import async_cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  hs_state_t          state;
  logic               ack_s;
  logic               push;
  logic               pop;
  logic               load;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack),
    .q     (ack_s)
  );

  assign fetch_ready = count < CW'(DEPTH);
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = (state == REQ) && ack_s;

  // In RELEASE the head already points past the word just popped.
  assign load = !flush && (count != '0) &&
                ((state == IDLE) ||
                 ((state == RELEASE) && !ack_s));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[tail] <= fetch_instr;
      pc_mem[tail]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (flush && state == REQ) begin
        tail  <= head + PW'(1);
        count <= pop ? '0 : CW'(1);
      end else if (flush) begin
        tail  <= head;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req       <= 1'b0;
      instr_out <= '0;
      pc_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            instr_out <= instr_mem[head];
            pc_out    <= pc_mem[head];
            req       <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req   <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (load) begin
            instr_out <= instr_mem[head];
            pc_out    <= pc_mem[head];
            req       <= 1'b1;
            state     <= REQ;
          end else if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_channel.sv
// Bench for if_id_channel: directed steps plus random traffic checked
// against a queue model of accepted words and a behavioural decode side.
module tb_if_id_channel;

  localparam int IW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 2;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [IW-1:0] fetch_instr;
  logic [AW-1:0] fetch_pc;
  logic          flush;
  logic          req;
  logic          ack;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  if_id_channel #(
    .INSTR_W     (IW),
    .PC_W        (AW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .req         (req),
    .ack         (ack),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .count       (count)
  );

  typedef logic [AW+IW-1:0] word_t;

  word_t pend[$];
  word_t got[$];
  int    rise_q[$];
  word_t cur;
  bit    inflight;
  bit    prev_req;
  bit    mon_en;
  bit    dec_en;
  bit    ack_auto;
  int    max_dly;
  int    dly;
  int    ecnt;
  int    ack_edge;
  int    checks;
  int    errors;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words accepted into the channel, in order of acceptance.
  always @(posedge clk) begin
    ecnt++;
    if (mon_en && !reset) begin
      if (flush) pend.delete();
      else if (fetch_valid && (pend.size() + int'(inflight)) < DEPTH)
        pend.push_back({fetch_pc, fetch_instr});
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      int occ;
      if (req && !prev_req) begin
        rise_q.push_back(ecnt);
        if (pend.size() == 0) begin
          chk("spurious_req", 64'(1), 64'(0));
        end else begin
          cur = pend.pop_front();
          got.push_back(cur);
        end
        inflight = 1'b1;
      end
      if (!req && prev_req) begin
        inflight = 1'b0;
        if (ack_auto) chk("req_fall_lat", 64'(ecnt - ack_edge), 64'(SYNC + 1));
        ack_auto = 1'b0;
      end
      if (req) chk("out_word", 64'({pc_out, instr_out}), 64'(cur));
      occ = pend.size() + int'(inflight);
      chk("count", 64'(count), 64'(occ));
      chk("fetch_ready", 64'(fetch_ready), 64'(occ < DEPTH));
      prev_req = req;
      if (dec_en) begin
        if (!ack) begin
          if (req) begin
            if (dly == 0) begin
              ack      = 1'b1;
              ack_edge = ecnt;
              ack_auto = 1'b1;
              dly      = $urandom_range(max_dly);
            end else dly--;
          end
        end else if (!req) begin
          if (dly == 0) begin
            ack = 1'b0;
            dly = $urandom_range(max_dly);
          end else dly--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] p, input logic [IW-1:0] i);
    int n = 0;
    fetch_pc    = p;
    fetch_instr = i;
    fetch_valid = 1'b1;
    while (!fetch_ready && n < 200) begin
      step(1);
      n++;
    end
    chk("push_timeout", 64'(n < 200), 64'(1));
    step(1);
    fetch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend.size() != 0 || inflight || req || ack) && n < 400) begin
      step(1);
      n++;
    end
    chk("idle_timeout", 64'(n < 400), 64'(1));
    step(SYNC + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; ecnt = 0; dly = 0; max_dly = 0;
    mon_en = 0; dec_en = 0; ack_auto = 0; inflight = 0; prev_req = 0;
    reset = 1'b1; ack = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    fetch_pc = '0; fetch_instr = '0;
    step(3);
    #2 reset = 1'b0;
    step(1);
    mon_en = 1;

    // Quiet after reset
    repeat (5) begin
      chk("rst_req", 64'(req), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_ready", 64'(fetch_ready), 64'(1));
      chk("rst_instr", 64'(instr_out), 64'(0));
      chk("rst_pc", 64'(pc_out), 64'(0));
      step(1);
    end

    // Single word, push-to-req latency
    dec_en = 1; max_dly = 1;
    push(8'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_req_lo", 64'(req), 64'(0));
    step(1);
    chk("lat_req_hi", 64'(req), 64'(1));
    chk("one_pc", 64'(pc_out), 64'(8'h10));
    chk("one_instr", 64'(instr_out), 64'(32'hDEADBEEF));
    wait_idle();
    chk("one_n", 64'(got.size()), 64'(1));
    chk("one_cnt", 64'(count), 64'(0));

    // Back-to-back with decode stalled, then instant decode
    got.delete(); rise_q.delete();
    dec_en = 0; ack = 1'b0; max_dly = 0; dly = 0;
    push(8'h00, 32'h1111_0000);
    push(8'h01, 32'h1111_0001);
    chk("full_ready", 64'(fetch_ready), 64'(0));
    chk("full_cnt", 64'(count), 64'(DEPTH));
    fetch_pc = 8'h02; fetch_instr = 32'h1111_0002; fetch_valid = 1'b1;
    step(3);
    chk("held_ready", 64'(fetch_ready), 64'(0));
    dec_en = 1;
    push(8'h02, 32'h1111_0002);
    wait_idle();
    chk("order_n", 64'(got.size()), 64'(3));
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk("order_pc", 64'(got[k][AW+IW-1:IW]), 64'(k));
    if (rise_q.size() >= 3)
      chk("cycle_len", 64'(rise_q[2] - rise_q[1]), 64'(2 * (SYNC + 1)));
    else
      chk("cycle_rises", 64'(rise_q.size()), 64'(3));

    // Flush while offering, FIFO full
    got.delete();
    dec_en = 0;
    push(8'h20, 32'h2222_0020);
    push(8'h21, 32'h2222_0021);
    chk("fl_req", 64'(req), 64'(1));
    chk("fl_cnt2", 64'(count), 64'(2));
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("fl_cnt1", 64'(count), 64'(1));
    chk("fl_req_kept", 64'(req), 64'(1));
    dec_en = 1;
    for (int n = 0; n < 50 && req; n++) step(1);
    chk("fl_req_fell", 64'(req), 64'(0));
    chk("fl_cnt0", 64'(count), 64'(0));
    push(8'h30, 32'h3333_0030);
    wait_idle();
    chk("fl_n", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("fl_head", 64'(got[0][AW+IW-1:IW]), 64'(8'h20));
      chk("fl_next", 64'(got[1][AW+IW-1:IW]), 64'(8'h30));
    end

    // Flush colliding with a push while idle
    got.delete();
    fetch_pc = 8'h40; fetch_instr = 32'h4444_0040;
    fetch_valid = 1'b1; flush = 1'b1;
    step(1);
    fetch_valid = 1'b0; flush = 1'b0;
    chk("fp_cnt", 64'(count), 64'(0));
    repeat (6) begin
      chk("fp_req", 64'(req), 64'(0));
      step(1);
    end
    chk("fp_n", 64'(got.size()), 64'(0));

    // Random traffic, random decode delays, occasional flush
    max_dly = 3;
    repeat (600) begin
      fetch_valid = 1'($urandom_range(0, 1));
      fetch_pc    = AW'($urandom);
      fetch_instr = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      step(1);
    end
    fetch_valid = 1'b0; flush = 1'b0;
    wait_idle();
    chk("rnd_drain", 64'(pend.size()), 64'(0));
    chk("rnd_cnt", 64'(count), 64'(0));

    // Reset in the middle of a handshake
    got.delete();
    dec_en = 0; max_dly = 0; dly = 0; ack = 1'b0;
    push(8'h50, 32'h5555_0050);
    step(1);
    chk("mr_req_hi", 64'(req), 64'(1));
    mon_en = 0;
    #2 reset = 1'b1;
    #1;
    chk("mr_req_async", 64'(req), 64'(0));
    chk("mr_cnt", 64'(count), 64'(0));
    chk("mr_ready", 64'(fetch_ready), 64'(1));
    chk("mr_pc", 64'(pc_out), 64'(0));
    pend.delete(); inflight = 0; prev_req = 0; ack_auto = 0;
    step(2);
    #2 reset = 1'b0;
    step(1);
    mon_en = 1; dec_en = 1;
    push(8'h55, 32'h5555_0055);
    wait_idle();
    chk("mr_n", 64'(got.size()), 64'(1));
    if (got.size() == 1)
      chk("mr_word", 64'(got[0]), 64'({8'h55, 32'h5555_0055}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_channel.md
# if_id_channel

Bundled-data channel between instruction fetch and instruction decode. It accepts `{pc, instr}` words from fetch with a valid/ready handshake and buffers them in a small FIFO. It presents the oldest word to the decode stage over a four-phase req/ack handshake. It is the sole driver of `req` toward decode, resynchronises decode's `ack` into the fetch clock domain, and discards wrong-path words when decode signals a taken branch.

## Interface
- `INSTR_W`, 32, instruction width
- `PC_W`, 8, program-counter width
- `DEPTH`, 2, FIFO entries (power of two, ≥2)
- `SYNC_STAGES`, 2, flops in the `ack` synchroniser (≥2)

- `clk` in 1: single clock (fetch clock domain).
- `reset` in 1: asynchronous, active-high.
- `fetch_valid` in 1: fetch presents a word this cycle.
- `fetch_ready` out 1: the channel can accept a word (`count < DEPTH`).
- `fetch_instr` in `INSTR_W`: instruction from fetch.
- `fetch_pc` in `PC_W`: PC of `fetch_instr`.
- `flush` in 1: taken branch reported by decode; discards buffered wrong-path words.
- `req` out 1: four-phase request to decode.
- `ack` in 1: four-phase acknowledge from decode; asynchronous to `clk`.
- `instr_out` out `INSTR_W`: instruction offered to decode.
- `pc_out` out `PC_W`: PC offered to decode.
- `count` out `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- Push: at a rising edge with `fetch_valid && fetch_ready && !flush`, write the word at the tail.
- Words arriving while `fetch_ready=0` are ignored; fetch must hold them.
- `ack_s` is `ack` passed through `SYNC_STAGES` flops. The FSM uses only `ack_s`.
- Handshake FSM states:
  - **IDLE** (`req=0`): if `count>0`, load `instr_out`/`pc_out` from the head, set `req←1`, go to REQ.
  - **REQ** (`req=1`; `instr_out`/`pc_out` frozen): when `ack_s=1`, pop the head, set `req←0`, go to RELEASE.
  - **RELEASE** (`req=0`): wait for `ack_s=0`.
    - If `count>0` at that edge (post-pop occupancy), load the new head, set `req←1`, go to REQ.
    - Otherwise go to IDLE.
- Push and pop on the same edge leave `count` unchanged. The pushed word must not overwrite the entry being popped.
- `flush`:
  - In IDLE or RELEASE: clear all entries (`count←0`) and drop any simultaneous push.
  - In REQ: clear every entry except the head being offered. The current transaction completes normally; decode is responsible for discarding that word.
  - `flush` never lowers `req` early.
- `req` is registered and never glitches. `instr_out`/`pc_out` change only on the edge where `req` rises.

## Timing
- Reset values:
  - `req=0`, `instr_out=0`, `pc_out=0`, `count=0`, FSM=IDLE.
  - `fetch_ready=1`.
  - Synchroniser flops and FIFO storage all 0.
- Reset mid-handshake: `req` falls immediately (asynchronously) and all contents are lost. Decode must return `ack` low before the channel next raises `req`.
- Push at edge N with the channel empty and in IDLE: `req=1` after edge N+1.
- `ack` rising at decode: seen as `ack_s` after `SYNC_STAGES` edges; `req` falls at the following edge.
- Minimum full cycle with an instantly-responding decode: `2·(SYNC_STAGES+1)` clocks per word.
- `fetch_ready` is combinational from `count` only, with no path from `fetch_valid`.
- Full (`count=DEPTH`) with a pop on edge N: `fetch_ready=1` after edge N.
- Pointers wrap modulo `DEPTH`.

## Structure
- Shared package `async_cpu_pkg`:
  - `INSTR_W`, `PC_W` constants.
  - `hs_state_t` enum {IDLE, REQ, RELEASE}, reused by the other four-phase stages.
- Sub-module `sync_ff` (parameter `STAGES`, asynchronous reset to 0) for `ack`. Reusable for `ack_wb_rf` and the other cross-clock acks.
- FIFO storage and pointers live inline.

## Test plan
- Reset release, no input → `req=0`, `count=0`, `fetch_ready=1`, `instr_out=0`, indefinitely.
- Push `{pc=0x10, instr=0xDEADBEEF}`; decode acks 1 cycle after `req` and drops `ack` 1 cycle after `req` falls → exactly one four-phase cycle, `pc_out=0x10`, outputs stable throughout REQ, `count` returns to 0.
- Push 3 words back-to-back with decode stalled (`ack=0`) → `fetch_ready=0` after the 2nd push and the 3rd word is held by fetch. Complete the handshakes → words delivered in order pc 0x00, 0x01, 0x02.
- `flush` while in REQ with `count=2` → head completes, `count=0` after that pop, and the next delivered word is the first word pushed after `flush`.
- `flush` coincident with a push in IDLE → `count=0`, `req` stays 0, and the pushed word is never delivered.
- Assert `reset` while `req=1` → `req` falls within the same cycle. After release, `ack` low, and one push → normal delivery.
